// File: rtl/alu_op_scheduler_if.sv
// Bundle of requester, arithmetic-unit and response signals around alu_op_scheduler.
// Handshakes: a request transfers on req_valid[i] & req_ready[i]; a response transfers on rsp_valid & rsp_ready.
interface alu_op_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
) ();
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [2*NUM_REQ-1:0]      req_opc;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      unit_start;
    logic [1:0]                unit_opc;
    logic [DATA_W-1:0]         unit_a;
    logic [DATA_W-1:0]         unit_b;
    logic                      unit_done;
    logic [2*DATA_W-1:0]       unit_result;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [2*DATA_W-1:0]       rsp_result;
    logic                      rsp_err;
    logic                      rsp_ready;
    logic                      busy;

    modport slave (
        input  req_valid, req_opc, req_a, req_b, unit_done, unit_result, rsp_ready,
        output req_ready, unit_start, unit_opc, unit_a, unit_b,
        output rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

    modport master (
        output req_valid, req_opc, req_a, req_b, unit_done, unit_result, rsp_ready,
        input  req_ready, unit_start, unit_opc, unit_a, unit_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one iterative arithmetic unit among NUM_REQ requesters,
// with one operation in flight, a done/timeout wait and a tagged response.
module alu_op_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_op_scheduler_if.slave      bus,
    output logic [1:0]             dbg_state
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [1:0]          opc_q, opc_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                err_q, err_d;

    logic                found;
    logic [ID_W-1:0]     winner;
    logic [1:0]          win_opc;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : arbitrate
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
        win_opc = bus.req_opc[2*int'(winner) +: 2];
    end

    always_comb begin : next_state
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        opc_d         = opc_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        result_d      = result_q;
        err_d         = err_q;
        bus.req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (found && !rst) begin
                    bus.req_ready[winner] = 1'b1;
                    id_d     = winner;
                    opc_d    = win_opc;
                    a_d      = bus.req_a[int'(winner)*DATA_W +: DATA_W];
                    b_d      = bus.req_b[int'(winner)*DATA_W +: DATA_W];
                    rr_ptr_d = ID_W'((int'(winner) + 1) % NUM_REQ);
                    result_d = '0;
                    // Reserved opcode is answered directly without touching the unit.
                    if (win_opc == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.unit_done) begin
                    result_d = bus.unit_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            opc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            opc_q    <= opc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.unit_start = (state_q == ISSUE);
    assign bus.unit_opc   = opc_q;
    assign bus.unit_a     = a_q;
    assign bus.unit_b     = b_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = (state_q == RESP) ? id_q : '0;
    assign bus.rsp_result = (state_q == RESP) ? result_q : '0;
    assign bus.rsp_err    = (state_q == RESP) ? err_q : 1'b0;
    assign bus.busy       = (state_q != IDLE);
    assign dbg_state      = state_q;
endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares one iterative arithmetic unit among NUM_REQ requesters. The unit is the control+datapath pair driven by start/opc_code.
- Round-robin arbitration picks one pending request, latches its operands and pulses unit start.
- It then waits for done, or aborts on timeout, and returns the tagged result to the requester.
- Sits between the requesters and the control unit. Exactly one operation is in flight at any time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand width; result width is 2*DATA_W
- TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_opc  in  2*NUM_REQ  opcode of requester i at bits [2i+1:2i]
- req_a  in  DATA_W*NUM_REQ  operand A of requester i
- req_b  in  DATA_W*NUM_REQ  operand B of requester i
- req_ready  out  NUM_REQ  one-hot grant; request i accepted on the cycle where req_valid[i]&req_ready[i]
- unit_start  out  1  one-cycle start pulse to the arithmetic unit
- unit_opc  out  2  latched opcode to the unit
- unit_a  out  DATA_W  latched operand A
- unit_b  out  DATA_W  latched operand B
- unit_done  in  1  unit completion pulse
- unit_result  in  2*DATA_W  unit result, valid when unit_done=1
- rsp_valid  out  1  response available
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response
- rsp_result  out  2*DATA_W  result (0 on error)
- rsp_err  out  1  1 = illegal opcode or timeout
- rsp_ready  in  1  response consumer accepts
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0, timeout counter 0. rst high in any state aborts the in-flight operation, and no response is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitration is combinational: search starts at rr_ptr and wraps modulo NUM_REQ. The first i with req_valid[i] wins.
  - req_ready[winner]=1 in the same cycle.
  - On acceptance: latch id, opc, a, b.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Next state: opc==2'b11 (reserved) -> RESP with rsp_err=1, result 0, unit not started. Otherwise -> ISSUE.
  - req_ready is 0 in every state except IDLE.
- ISSUE:
  - unit_start=1 for exactly this one cycle.
  - unit_opc/a/b are held stable from ISSUE until leaving WAIT.
  - Next state -> WAIT; counter cleared.
- WAIT:
  - Counter increments each cycle.
  - unit_done=1 -> latch unit_result and go to RESP with err=0. This can happen on the first WAIT cycle, giving minimum latency of grant +3 cycles to rsp_valid.
  - Counter reaching TIMEOUT-1 without done -> RESP with err=1, result 0.
  - If done and timeout occur in the same cycle, done wins.
  - unit_done outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id/result/err are held stable until rsp_ready.
  - rsp_valid & rsp_ready -> IDLE. The next arbitration happens in the following cycle (no same-cycle re-grant).
- A requester dropping req_valid before it is granted is legal and is simply not served.
- Starvation bound: a continuously valid requester is granted within NUM_REQ grants.
- busy = (state != IDLE).

Test Plan:
- Reset, then req_valid=4'b0001, opc=0, a=3, b=5; unit_done after 4 cycles with result 15 -> req_ready[0] in grant cycle; unit_start one pulse with unit_a=3, unit_b=5; rsp_valid with rsp_id=0, rsp_result=15, rsp_err=0; busy drops after rsp_ready.
- req_valid=4'b1111 held, each done after 2 cycles -> grant order 0,1,2,3,0; rr_ptr wraps correctly.
- Illegal opcode 2'b11 from requester 2 -> unit_start never asserted; rsp_id=2, rsp_err=1, rsp_result=0.
- unit_done withheld -> after TIMEOUT=64 WAIT cycles, rsp_err=1; a late unit_done afterward is ignored.
- rsp_ready held low 10 cycles with other requests pending -> rsp fields stable, req_ready all 0, no new unit_start.
- rst asserted mid-WAIT -> next cycle all outputs 0, state IDLE, rr_ptr=0; the following request proceeds normally.
